// File: rtl/spi_sr_responder_if.sv
// Serial-side lines between an SPI master and the spi_sr_responder chip model.
// The master drives clock, data, frame enable and load; the responder drives SDO.
interface spi_sr_responder_if;
    logic SCLK;
    logic SDI;
    logic SEN;
    logic SLD;
    logic SDO;

    modport master (output SCLK, output SDI, output SEN, output SLD, input SDO);
    modport slave  (input SCLK, input SDI, input SEN, input SLD, output SDO);
endinterface

// File: rtl/spi_sr_responder.sv
// Device-side end of the basil SPI link: oversampled serial shift register with
// bus preload, SDO readback stream and an SLD-triggered bus-readable latch.
module spi_sr_responder #(
    parameter BASEADDR    = 16'h0000,
    parameter HIGHADDR    = 16'h0000,
    parameter ABUSWIDTH   = 16,
    parameter SR_BYTES    = 16,
    parameter SYNC_STAGES = 2
) (
    input  wire                 BUS_CLK,
    input  wire                 BUS_RST,
    input  wire [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire [7:0]           BUS_DATA,
    input  wire                 BUS_RD,
    input  wire                 BUS_WR,
    spi_sr_responder_if.slave   spi
);

    localparam int SR_BITS = 8 * SR_BYTES;
    localparam logic [ABUSWIDTH-1:0] SPAN       = ABUSWIDTH'(HIGHADDR - BASEADDR);
    localparam logic [ABUSWIDTH-1:0] OFF_CTRL   = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] OFF_STATUS = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] OFF_CNT_LO = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] OFF_CNT_HI = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] OFF_SR     = ABUSWIDTH'(16);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [SR_BITS-1:0]   sr;
    logic [SR_BITS-1:0]   sr_shift;
    logic [SR_BITS-1:0]   sr_next;
    logic [SR_BITS-1:0]   latch;
    logic [15:0]          bit_count;
    logic                 overflow;
    logic                 loaded;
    logic                 sdo_q;
    logic [7:0]           rd_data;
    logic [7:0]           rd_mux;
    logic                 rd_q;

    logic [ABUSWIDTH-1:0] offset;
    logic                 in_range;
    logic                 wr_en;
    logic                 rd_en;
    logic                 rst;
    logic [7:0]           wr_data;

    // SDI needs no edge detection, so it carries no history flop; its depth
    // matches SCLK so the sampled bit lines up with the detected edge.
    logic [SYNC_STAGES:0]   sclk_sync;
    logic [SYNC_STAGES:0]   sen_sync;
    logic [SYNC_STAGES:0]   sld_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;

    logic sclk_rise, sclk_fall, sen_rise, sen_fall, sld_rise, sdi_s;

    assign offset   = BUS_ADD - ABUSWIDTH'(BASEADDR);
    assign in_range = (offset <= SPAN);
    assign wr_en    = BUS_WR && in_range;
    assign rd_en    = BUS_RD && in_range;
    assign wr_data  = BUS_DATA;
    assign rst      = BUS_RST || (wr_en && offset == OFF_CTRL);

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
    assign sen_rise  = sen_sync[SYNC_STAGES-1] & ~sen_sync[SYNC_STAGES];
    assign sen_fall  = ~sen_sync[SYNC_STAGES-1] & sen_sync[SYNC_STAGES];
    assign sld_rise  = sld_sync[SYNC_STAGES-1] & ~sld_sync[SYNC_STAGES];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];

    assign spi.SDO  = sdo_q;
    assign BUS_DATA = rd_q ? rd_data : 8'hzz;

    // Clearing to zero makes an input that is already high look like a fresh
    // rising edge, which is how a held SEN restarts the frame after reset.
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            sclk_sync <= '0;
            sen_sync  <= '0;
            sld_sync  <= '0;
            sdi_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], spi.SCLK};
            sen_sync  <= {sen_sync[SYNC_STAGES-1:0], spi.SEN};
            sld_sync  <= {sld_sync[SYNC_STAGES-1:0], spi.SLD};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi.SDI};
        end
    end

    // sr_shift is what the latch sees, so a coincident preload never leaks in.
    always_comb begin
        sr_shift = sr;
        if (state == SHIFT && sclk_rise) begin
            sr_shift = {sr[SR_BITS-2:0], sdi_s};
        end
        sr_next = sr_shift;
        if (state == IDLE && wr_en) begin
            for (int k = 0; k < SR_BYTES; k++) begin
                if (offset == OFF_SR + ABUSWIDTH'(k)) begin
                    sr_next[SR_BITS-1-8*k -: 8] = wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (offset == OFF_CTRL) begin
            rd_mux = 8'd1;
        end else if (offset == OFF_STATUS) begin
            rd_mux = {5'b0, loaded, overflow, state == SHIFT};
        end else if (offset == OFF_CNT_LO) begin
            rd_mux = bit_count[7:0];
        end else if (offset == OFF_CNT_HI) begin
            rd_mux = bit_count[15:8];
        end else begin
            for (int k = 0; k < SR_BYTES; k++) begin
                if (offset == OFF_SR + ABUSWIDTH'(k)) begin
                    rd_mux = latch[SR_BITS-1-8*k -: 8];
                end
            end
        end
    end

    // Frame FSM plus all bus-visible state; the sticky-bit clear is placed
    // before the set paths so a same-cycle event still gets recorded.
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            latch     <= '0;
            bit_count <= '0;
            overflow  <= 1'b0;
            loaded    <= 1'b0;
            sdo_q     <= 1'b0;
            rd_data   <= '0;
            rd_q      <= 1'b0;
        end else begin
            sr   <= sr_next;
            rd_q <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
            if (wr_en && offset == OFF_STATUS) begin
                overflow <= 1'b0;
                loaded   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sen_rise) begin
                        state     <= SHIFT;
                        bit_count <= '0;
                        sdo_q     <= sr[SR_BITS-1];
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_count != 16'hFFFF) begin
                            bit_count <= bit_count + 16'd1;
                        end
                        if (bit_count == 16'(SR_BITS)) begin
                            overflow <= 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        sdo_q <= sr[SR_BITS-1];
                    end
                    if (sen_fall) begin
                        state <= IDLE;
                    end
                end
            endcase
            if (sld_rise) begin
                latch  <= sr_shift;
                loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_sr_responder.sv
// Directed self-checking bench for spi_sr_responder with a 2-byte shift register;
// the SPI master runs at 4 BUS_CLK cycles per SCLK phase.
module tb_spi_sr_responder;

    localparam logic [15:0] BASE = 16'h1000;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [15:0] BUS_ADD;
    logic        BUS_RD;
    logic        BUS_WR;
    logic        tb_drive;
    logic [7:0]  tb_data;
    wire  [7:0]  BUS_DATA;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  rd;
    logic [31:0] rx;

    always #5 BUS_CLK = ~BUS_CLK;

    assign BUS_DATA = tb_drive ? tb_data : 8'hzz;

    spi_sr_responder_if spi_if ();

    spi_sr_responder #(
        .BASEADDR   (16'h1000),
        .HIGHADDR   (16'h101F),
        .ABUSWIDTH  (16),
        .SR_BYTES   (2),
        .SYNC_STAGES(2)
    ) dut (
        .BUS_CLK (BUS_CLK),
        .BUS_RST (BUS_RST),
        .BUS_ADD (BUS_ADD),
        .BUS_DATA(BUS_DATA),
        .BUS_RD  (BUS_RD),
        .BUS_WR  (BUS_WR),
        .spi     (spi_if.slave)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [15:0] off, input logic [7:0] data);
        @(negedge BUS_CLK);
        BUS_ADD  = BASE + off;
        tb_data  = data;
        tb_drive = 1'b1;
        BUS_WR   = 1'b1;
        @(negedge BUS_CLK);
        BUS_WR   = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] off, output logic [7:0] data);
        @(negedge BUS_CLK);
        BUS_ADD = BASE + off;
        BUS_RD  = 1'b1;
        @(negedge BUS_CLK);
        BUS_RD  = 1'b0;
        data    = BUS_DATA;
    endtask

    task automatic check_reg(input string tag, input logic [15:0] off, input logic [7:0] expected);
        logic [7:0] d;
        bus_read(off, d);
        check_output(tag, {24'h0, d}, {24'h0, expected});
    endtask

    task automatic frame_start();
        spi_if.SEN = 1'b1;
        repeat (6) @(negedge BUS_CLK);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge BUS_CLK);
        spi_if.SEN = 1'b0;
        repeat (6) @(negedge BUS_CLK);
    endtask

    task automatic sld_pulse();
        spi_if.SLD = 1'b1;
        repeat (4) @(negedge BUS_CLK);
        spi_if.SLD = 1'b0;
        repeat (4) @(negedge BUS_CLK);
    endtask

    // Master samples SDO late in the low phase; in loopback SDI copies that sample.
    task automatic apply_stimulus(input int n, input logic [31:0] data, input logic loopback,
                                  input int sld_bit, output logic [31:0] stream);
        logic o;
        stream = '0;
        for (int i = 0; i < n; i++) begin
            if (!loopback) spi_if.SDI = data[n-1-i];
            repeat (3) @(negedge BUS_CLK);
            o = spi_if.SDO;
            if (loopback) spi_if.SDI = o;
            @(negedge BUS_CLK);
            spi_if.SCLK = 1'b1;
            if (i == sld_bit) spi_if.SLD = 1'b1;
            repeat (4) @(negedge BUS_CLK);
            spi_if.SCLK = 1'b0;
            stream = {stream[30:0], o};
        end
    endtask

    initial begin
        BUS_RST     = 1'b1;
        BUS_ADD     = '0;
        BUS_RD      = 1'b0;
        BUS_WR      = 1'b0;
        tb_drive    = 1'b0;
        tb_data     = '0;
        spi_if.SCLK = 1'b0;
        spi_if.SDI  = 1'b0;
        spi_if.SEN  = 1'b0;
        spi_if.SLD  = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        @(negedge BUS_CLK);

        $display("[TB] reset state");
        check_output("reset_sdo", {31'h0, spi_if.SDO}, 32'h0);
        check_reg("reset_version", 16'd0, 8'h01);
        check_reg("reset_status", 16'd1, 8'h00);
        check_reg("reset_count_lo", 16'd2, 8'h00);
        check_reg("reset_latch0", 16'd16, 8'h00);

        $display("[TB] basic frame: preload A5 3C, send 1234");
        bus_write(16'd16, 8'hA5);
        bus_write(16'd17, 8'h3C);
        frame_start();
        apply_stimulus(16, 32'h1234, 1'b0, -1, rx);
        frame_end();
        sld_pulse();
        check_output("basic_sdo_stream", rx, 32'h0000A53C);
        check_reg("basic_latch0", 16'd16, 8'h12);
        check_reg("basic_latch1", 16'd17, 8'h34);
        check_reg("basic_count_lo", 16'd2, 8'h10);
        check_reg("basic_count_hi", 16'd3, 8'h00);
        check_reg("basic_status", 16'd1, 8'h04);

        $display("[TB] loopback overflow: 32 bits into 16-bit register");
        bus_write(16'd1, 8'h00);
        frame_start();
        apply_stimulus(32, 32'h0, 1'b1, -1, rx);
        frame_end();
        sld_pulse();
        check_output("loop_sdo_stream", rx, 32'h12341234);
        check_reg("loop_count_lo", 16'd2, 8'h20);
        check_reg("loop_status", 16'd1, 8'h06);
        check_reg("loop_latch0", 16'd16, 8'h12);
        check_reg("loop_latch1", 16'd17, 8'h34);

        $display("[TB] preload during frame is dropped");
        bus_write(16'd1, 8'h00);
        frame_start();
        check_reg("shift_status", 16'd1, 8'h01);
        bus_write(16'd16, 8'hFF);
        apply_stimulus(16, 32'h0, 1'b0, -1, rx);
        frame_end();
        check_output("drop_sdo_stream", rx, 32'h00001234);

        $display("[TB] reset mid-frame with SEN held");
        bus_write(16'd16, 8'h5A);
        bus_write(16'd17, 8'hC3);
        frame_start();
        apply_stimulus(5, 32'h1F, 1'b0, -1, rx);
        @(negedge BUS_CLK);
        BUS_RST = 1'b1;
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        repeat (6) @(negedge BUS_CLK);
        apply_stimulus(16, 32'hBEEF, 1'b0, -1, rx);
        frame_end();
        sld_pulse();
        check_output("rst_sdo_stream", rx, 32'h0);
        check_reg("rst_count_lo", 16'd2, 8'h10);
        check_reg("rst_latch0", 16'd16, 8'hBE);
        check_reg("rst_latch1", 16'd17, 8'hEF);

        $display("[TB] SLD coincident with 16th SCLK rise");
        bus_write(16'd1, 8'h00);
        frame_start();
        apply_stimulus(16, 32'h9C61, 1'b0, 15, rx);
        frame_end();
        spi_if.SLD = 1'b0;
        repeat (4) @(negedge BUS_CLK);
        check_reg("coinc_latch0", 16'd16, 8'h9C);
        check_reg("coinc_latch1", 16'd17, 8'h61);
        check_reg("coinc_status", 16'd1, 8'h04);

        $display("[TB] status clear, version, unmapped, soft reset");
        bus_write(16'd1, 8'hFF);
        check_reg("clear_status", 16'd1, 8'h00);
        check_reg("version", 16'd0, 8'h01);
        check_reg("unmapped_4", 16'd4, 8'h00);
        check_reg("unmapped_18", 16'd18, 8'h00);
        bus_write(16'd0, 8'h00);
        check_reg("soft_rst_count", 16'd2, 8'h00);
        check_reg("soft_rst_latch0", 16'd16, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
